// File: rtl/uart_frame_pkg.sv
// Shared types for the UART frame controller: FSM states, error codes and the
// default SYNC marker. The S_CHK state exists only when UART_FRAME_CHKSUM_EN
// is defined.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DEST    = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3
`ifdef UART_FRAME_CHKSUM_EN
    , S_CHK   = 3'd4
`endif
  } state_t;

  typedef enum logic [1:0] {
    ERR_BAD_CHK  = 2'd0,
    ERR_BAD_DEST = 2'd1,
    ERR_BAD_LEN  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_t;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-stream and payload bundle of the UART frame controller.
//   rx_data/rx_valid                 : received bytes from the UART receiver
//   pl_data/pl_valid/pl_dest/pl_last : payload stream to the consumers
//   frame_ok/frame_err/err_code      : frame completion status
//   busy                             : controller is inside a frame
// slave = the frame controller, master = the receiver/consumer side.
interface uart_rx_frame_ctrl_if
  import uart_frame_pkg::*;
#(
  parameter int unsigned DEST_W = 2
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        pl_data;
  logic              pl_valid;
  logic [DEST_W-1:0] pl_dest;
  logic              pl_last;
  logic              frame_ok;
  logic              frame_err;
  err_code_t         err_code;
  logic              busy;

  modport master (
    output rx_data, rx_valid,
    input  pl_data, pl_valid, pl_dest, pl_last, frame_ok, frame_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output pl_data, pl_valid, pl_dest, pl_last, frame_ok, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_timeout_timer.sv
// Inter-byte timeout timer.
//   clk, rst : clock, synchronous active-high reset
//   run      : count while high, clear while low
//   kick     : clear the count (a byte arrived)
//   expired  : same-cycle pulse in the cycle the count sits at CYCLES-1;
//              suppressed by kick so an arriving byte always wins
module uart_timeout_timer #(
  parameter int unsigned CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expired
);
  localparam int unsigned CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             at_limit;

  assign at_limit = (cnt_q == CNT_W'(CYCLES - 1));
  assign expired  = run && !kick && at_limit;

  // Saturating count; cleared on reset, on every byte and while idle.
  always_ff @(posedge clk) begin
    if (rst || kick || !run) begin
      cnt_q <= '0;
    end else if (!at_limit) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART frame controller: hunts SYNC, decodes DEST/LEN, streams LEN payload
// bytes to destination DEST and reports frame_ok / frame_err (+err_code).
// Optional trailing XOR checksum byte enabled by macro UART_FRAME_CHKSUM_EN.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_rx_frame_ctrl_if.slave (rx byte stream in, payload/status out)
// All bus outputs are registered, one clk after the causing rx_valid.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY_HZ = 50_000_000,
  parameter logic [7:0]  SYNC_BYTE        = SYNC_BYTE_DEFAULT,
  parameter int unsigned NUM_DEST         = 4,
  parameter int unsigned MAX_LEN          = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 100_000
) (
  input logic                clk,
  input logic                rst,
  uart_rx_frame_ctrl_if.slave bus
);
  localparam int unsigned DEST_W = $clog2(NUM_DEST);
  localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1);

  // Reject configurations the datapath widths cannot represent.
  if (CLK_FREQUENCY_HZ == 0 || NUM_DEST < 2 || NUM_DEST > 256 ||
      MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_rx_frame_ctrl: unsupported parameter set");
  end

  state_t            state_q, state_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        pl_data_q, pl_data_d;
  logic              pl_valid_q, pl_valid_d;
  logic              pl_last_q, pl_last_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  err_code_t         code_q, code_d;
  logic              busy_q;
  logic              tmo_expired;
`ifdef UART_FRAME_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  uart_timeout_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (state_q != S_IDLE),
    .kick    (bus.rx_valid),
    .expired (tmo_expired)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    pl_data_d  = pl_data_q;
    pl_valid_d = 1'b0;
    pl_last_d  = 1'b0;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
`ifdef UART_FRAME_CHKSUM_EN
    chk_d      = chk_q;
`endif
    if (bus.rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.rx_data == SYNC_BYTE) begin
            state_d = S_DEST;
            cnt_d   = '0;
`ifdef UART_FRAME_CHKSUM_EN
            chk_d   = 8'h00;
`endif
          end
        end
        S_DEST: begin
          if (32'(bus.rx_data) < NUM_DEST) begin
            dest_d  = DEST_W'(bus.rx_data);
            state_d = S_LEN;
`ifdef UART_FRAME_CHKSUM_EN
            chk_d   = chk_q ^ bus.rx_data;
`endif
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_DEST;
            state_d = S_IDLE;
          end
        end
        S_LEN: begin
          if (bus.rx_data != 8'h00 && 32'(bus.rx_data) <= MAX_LEN) begin
            len_d   = CNT_W'(bus.rx_data);
            state_d = S_PAYLOAD;
`ifdef UART_FRAME_CHKSUM_EN
            chk_d   = chk_q ^ bus.rx_data;
`endif
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_LEN;
            state_d = S_IDLE;
          end
        end
        S_PAYLOAD: begin
          pl_valid_d = 1'b1;
          pl_data_d  = bus.rx_data;
          cnt_d      = cnt_q + CNT_W'(1);
`ifdef UART_FRAME_CHKSUM_EN
          chk_d      = chk_q ^ bus.rx_data;
`endif
          if (cnt_q + CNT_W'(1) == len_q) begin
            pl_last_d = 1'b1;
`ifdef UART_FRAME_CHKSUM_EN
            state_d   = S_CHK;
`else
            ok_d      = 1'b1;
            state_d   = S_IDLE;
`endif
          end
        end
`ifdef UART_FRAME_CHKSUM_EN
        S_CHK: begin
          if (bus.rx_data == chk_q) begin
            ok_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_BAD_CHK;
          end
          state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
    // Timer never expires in a cycle carrying a byte, so this cannot collide.
    if (tmo_expired) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = S_IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dest_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      pl_data_q  <= 8'h00;
      pl_valid_q <= 1'b0;
      pl_last_q  <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_BAD_CHK;
      busy_q     <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      pl_data_q  <= pl_data_d;
      pl_valid_q <= pl_valid_d;
      pl_last_q  <= pl_last_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      code_q     <= code_d;
      busy_q     <= (state_d != S_IDLE);
`ifdef UART_FRAME_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign bus.pl_data   = pl_data_q;
  assign bus.pl_valid  = pl_valid_q;
  assign bus.pl_dest   = dest_q;
  assign bus.pl_last   = pl_last_q;
  assign bus.frame_ok  = ok_q;
  assign bus.frame_err = err_q;
  assign bus.err_code  = code_q;
  assign bus.busy      = busy_q;
endmodule
